// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, parameter defaults and counter widths for the memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} arb_state_e;
  localparam int ACC_LAT_DEF    = 2;
  localparam int STARVE_MAX_DEF = 4;
  localparam int LAT_W          = 4;
  localparam int STARVE_W       = 4;
endpackage

// File: rtl/arb_lat_counter.sv
// arb_lat_counter: loadable down-counter that stops at zero and flags it.
module arb_lat_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [LAT_W-1:0] load_val_i,
  output logic             zero_o
);
  logic [LAT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d  = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - LAT_W'(1) : cnt_q;
    zero_o = cnt_q == '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between instruction fetch and load/store,
// MEM first with a starvation guard for IF; one transaction per ACC_LAT+2 cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ACC_LAT    = ACC_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        mem_rd_req,
  input  logic        mem_wr_req,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        grant_mem
);
  localparam logic [LAT_W-1:0]    LAT_LOAD = LAT_W'(ACC_LAT - 1);
  localparam logic [STARVE_W-1:0] SMAX     = STARVE_W'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic [31:0]         addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]         if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic                we_q, we_d, own_mem_q, own_mem_d, flush_q, flush_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                mem_any, grant_if, grant_m, busy, lat_zero, fin;

  arb_lat_counter u_lat (
    .clk       (clk),
    .rst       (rst),
    .load_i    (grant_if | grant_m),
    .dec_i     (busy),
    .load_val_i(LAT_LOAD),
    .zero_o    (lat_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    mem_any  = mem_rd_req | mem_wr_req;
    grant_if = state_q == IDLE && if_req && (!mem_any || (starve_q == SMAX));
    grant_m  = state_q == IDLE && mem_any && !grant_if;
    busy     = state_q == BUSY_IF || state_q == BUSY_MEM;
    fin      = busy && lat_zero;
    state_d  = grant_m ? BUSY_MEM : grant_if ? BUSY_IF : fin ? DONE : state_q == DONE ? IDLE : state_q;
  end

  // A flush seen anywhere in BUSY_IF, including its last cycle, drops that fetch's result.
  always_comb begin
    addr_d      = grant_m ? mem_addr & ~32'h3 : grant_if ? if_addr & ~32'h3 : addr_q;
    wdata_d     = grant_m ? mem_wdata : grant_if ? '0 : wdata_q;
    we_d        = grant_m ? mem_wr_req : grant_if ? 1'b0 : we_q;
    own_mem_d   = grant_m ? 1'b1 : grant_if ? 1'b0 : own_mem_q;
    starve_d    = (!if_req || grant_if) ? '0 : (grant_m && starve_q < SMAX) ? starve_q + STARVE_W'(1) : starve_q;
    flush_d     = state_q == BUSY_IF ? flush_q | if_flush : state_q == DONE ? flush_q : 1'b0;
    if_rdata_d  = (fin && state_q == BUSY_IF && !(flush_q | if_flush)) ? ram_rdata : if_rdata_q;
    mem_rdata_d = (fin && state_q == BUSY_MEM && !we_q) ? ram_rdata : mem_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      own_mem_q   <= 1'b0;
      starve_q    <= '0;
      flush_q     <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      own_mem_q   <= own_mem_d;
      starve_q    <= starve_d;
      flush_q     <= flush_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    ram_en    = busy;
    ram_we    = state_q == BUSY_MEM && we_q;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if_ready  = state_q == DONE && !own_mem_q && !flush_q;
    mem_ready = state_q == DONE && own_mem_q;
    if_rdata  = if_rdata_q;
    mem_rdata = mem_rdata_q;
    grant_mem = own_mem_q;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ACC_LAT, default 2, meaning RAM access cycles per transaction (legal range 1..15).
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning consecutive MEM grants tolerated while if_req is pending.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports if_req (in, 1), if_addr (in, 32), if_flush (in, 1), if_ready (out, 1) and if_rdata (out, 32): the instruction-fetch requester.
REQ-006 SHALL have ports mem_rd_req (in, 1), mem_wr_req (in, 1), mem_addr (in, 32), mem_wdata (in, 32), mem_ready (out, 1) and mem_rdata (out, 32): the load/store requester.
REQ-007 SHALL have ports ram_en (out, 1), ram_we (out, 1), ram_addr (out, 32), ram_wdata (out, 32) and ram_rdata (in, 32): the shared single-port memory.
REQ-008 SHALL have port grant_mem, output, 1 bit: high while the current or last transaction belongs to MEM.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY_IF, BUSY_MEM and DONE.
REQ-010 IDLE SHALL leave a request unsampled if both requesters are idle, and SHALL grant MEM (mem_rd_req|mem_wr_req) over IF unless the starvation counter equals STARVE_MAX with if_req high, in which case IF is granted.
REQ-011 On grant, SHALL latch addr (bits[1:0] forced 0), wdata and we (mem_wr_req), load lat_cnt=ACC_LAT-1, and enter BUSY_IF or BUSY_MEM.
REQ-012 In BUSY_*, SHALL hold ram_en=1 and the latched ram_addr/ram_wdata; ram_we=latched we in BUSY_MEM, 0 in BUSY_IF; lat_cnt decrements each cycle.
REQ-013 In BUSY_* with lat_cnt==0, SHALL register ram_rdata into the owner's rdata and enter DONE.
REQ-014 DONE SHALL last exactly one cycle with the owner's ready=1, ram_en=0 and no new grant, then return to IDLE.
REQ-015 Request-to-ready latency SHALL be ACC_LAT+1 cycles, i.e. one transaction per ACC_LAT+2 cycles.
REQ-016 if_rdata/mem_rdata SHALL hold their value until that requester's next completion.
REQ-017 mem_rd_req and mem_wr_req both high SHALL be treated as a write.
REQ-018 On a write completion, mem_rdata SHALL be left unchanged; mem_ready still pulses.
REQ-019 Starvation counter: SHALL increment on each MEM grant while if_req=1, clear on any IF grant or when if_req=0, and saturate at STARVE_MAX.
REQ-020 if_flush in BUSY_IF SHALL let the RAM access finish, suppress that if_ready pulse and leave if_rdata unchanged; DONE still occurs.
REQ-021 if_flush in other states SHALL have no effect.
REQ-022 Requests SHALL be sampled only in IDLE; request deassertion during BUSY SHALL NOT abort the access.

Reset
REQ-023 rst high SHALL asynchronously force state IDLE, lat_cnt=0, starvation counter=0 and a flush-pending flag of 0.
REQ-024 rst high SHALL asynchronously force all outputs to 0: ram_en, ram_we, ram_addr, ram_wdata, if_ready, mem_ready, if_rdata, mem_rdata and grant_mem.
REQ-025 Reset mid-transaction SHALL abandon it with no ready pulse; after release, the first grant follows REQ-010 normally.

Structure
REQ-026 Shared package mem_arb_pkg SHALL hold the state enum, the ACC_LAT/STARVE_MAX defaults and the counter widths.
REQ-027 One sub-module, arb_lat_counter (loadable down-counter with zero flag), is natural; the FSM and starvation counter SHALL stay in mem_port_arbiter.

Verification
REQ-028 Reset then if_req, if_addr=0, RAM word 0=32'hE3A00014, ACC_LAT=2 -> ram_en high 2 cycles, if_ready pulse 3 cycles after request, if_rdata=32'hE3A00014.
REQ-029 Simultaneous if_req (addr 4) and mem_rd_req (addr 0x40) in IDLE -> MEM served first, then IF; grant_mem 1 then 0.
REQ-030 mem_wr_req, addr 0x10, wdata 32'h0000_0123 -> ram_we=1 for 2 cycles, mem_ready pulse, mem_rdata unchanged; readback of 0x10 returns 32'h0000_0123.
REQ-031 Continuous mem_rd_req plus if_req, STARVE_MAX=4 -> 5th grant goes to IF, then the counter clears.
REQ-032 if_flush pulsed in the cycle after an IF grant -> no if_ready, if_rdata unchanged, next IDLE grants normally.
REQ-033 rst asserted during BUSY_MEM -> all outputs 0 immediately (asynchronously), no mem_ready, and a fresh request after release completes in ACC_LAT+1 cycles.
